// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: opcodes, access
// sizes, FSM states and the opcode decoder.
package mem_access_ctrl_pkg;

    localparam logic [10:0] OPC_D_STURB  = 11'h1C0;
    localparam logic [10:0] OPC_D_LDURB  = 11'h1C2;
    localparam logic [10:0] OPC_D_LDURSB = 11'h1C4;
    localparam logic [10:0] OPC_D_STURH  = 11'h3C0;
    localparam logic [10:0] OPC_D_LDURH  = 11'h3C2;
    localparam logic [10:0] OPC_D_LDURSH = 11'h3C4;
    localparam logic [10:0] OPC_D_STURW  = 11'h5C0;
    localparam logic [10:0] OPC_D_LDURSW = 11'h5C4;
    localparam logic [10:0] OPC_D_STXR   = 11'h640;
    localparam logic [10:0] OPC_D_LDXR   = 11'h642;
    localparam logic [10:0] OPC_D_STUR   = 11'h7C0;
    localparam logic [10:0] OPC_D_LDUR   = 11'h7C2;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} state_e;

    typedef struct packed {
        size_e size;
        logic  sgn;
        logic  write;
        logic  excl;
        logic  legal;
    } dec_t;

    function automatic dec_t decode_op(input logic [10:0] opcode);
        dec_t d;
        d       = '0;
        d.legal = 1'b1;
        case (opcode)
            OPC_D_STURB:  begin d.size = SZ_B; d.write = 1'b1; end
            OPC_D_LDURB:  d.size = SZ_B;
            OPC_D_LDURSB: begin d.size = SZ_B; d.sgn = 1'b1; end
            OPC_D_STURH:  begin d.size = SZ_H; d.write = 1'b1; end
            OPC_D_LDURH:  d.size = SZ_H;
            OPC_D_LDURSH: begin d.size = SZ_H; d.sgn = 1'b1; end
            OPC_D_STURW:  begin d.size = SZ_W; d.write = 1'b1; end
            OPC_D_LDURSW: begin d.size = SZ_W; d.sgn = 1'b1; end
            OPC_D_STUR:   begin d.size = SZ_D; d.write = 1'b1; end
            OPC_D_LDUR:   d.size = SZ_D;
            OPC_D_LDXR:   begin d.size = SZ_D; d.excl = 1'b1; end
            OPC_D_STXR:   begin d.size = SZ_D; d.write = 1'b1; d.excl = 1'b1; end
            default:      d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic logic misaligned(input size_e sz, input logic [2:0] offset);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return offset[0];
            SZ_W:    return |offset[1:0];
            default: return |offset;
        endcase
    endfunction

    function automatic logic [7:0] size_mask(input size_e sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Core-side request/response handshake plus the memory-side access bus.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] opcode;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_ack;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport slave (
        input  req_valid, opcode, addr, wdata, rsp_ready, mem_ack, mem_rdata,
        output req_ready, rsp_valid, rdata, rsp_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output req_valid, opcode, addr, wdata, rsp_ready, mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rdata, rsp_err,
               mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );
endinterface

// File: rtl/mem_lane_extend.sv
// Moves the addressed lane of a read doubleword down to bit 0 and
// sign- or zero-extends it to 64 bits according to the access size.
module mem_lane_extend
    import mem_access_ctrl_pkg::*;
(
    input  logic [63:0] data,
    input  logic [2:0]  offset,
    input  size_e       size,
    input  logic        sgn,
    output logic [63:0] ext
);
    logic [63:0] shifted;

    always_comb begin
        shifted = data >> {offset, 3'b000};
        ext     = shifted;
        case (size)
            SZ_B:    ext = {{56{sgn & shifted[7]}},  shifted[7:0]};
            SZ_H:    ext = {{48{sgn & shifted[15]}}, shifted[15:0]};
            SZ_W:    ext = {{32{sgn & shifted[31]}}, shifted[31:0]};
            default: ext = shifted;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller: one request at a time, drives a variable-latency
// 64-bit memory, extends load data and tracks an LDXR/STXR exclusive monitor.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_access_ctrl_if.slave bus
);
    state_e      state_reg, state_next;
    logic [63:0] addr_reg, addr_next;
    logic [63:0] wdata_reg, wdata_next;
    logic [7:0]  be_reg, be_next;
    size_e       size_reg, size_next;
    logic        sgn_reg, sgn_next;
    logic        write_reg, write_next;
    logic        excl_reg, excl_next;
    logic [63:0] rdata_reg, rdata_next;
    logic        err_reg, err_next;
    logic        mon_valid_reg, mon_valid_next;
    logic [60:0] mon_tag_reg, mon_tag_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [63:0] load_ext;
    dec_t        dec;
    logic        tag_hit_in;

    mem_lane_extend u_extend (
        .data   (bus.mem_rdata),
        .offset (addr_reg[2:0]),
        .size   (size_reg),
        .sgn    (sgn_reg),
        .ext    (load_ext)
    );

    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        be_next        = be_reg;
        size_next      = size_reg;
        sgn_next       = sgn_reg;
        write_next     = write_reg;
        excl_next      = excl_reg;
        rdata_next     = rdata_reg;
        err_next       = err_reg;
        mon_valid_next = mon_valid_reg;
        mon_tag_next   = mon_tag_reg;
        cnt_next       = cnt_reg;
        dec            = decode_op(bus.opcode);
        tag_hit_in     = mon_valid_reg && (mon_tag_reg == bus.addr[63:3]);

        case (state_reg)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    addr_next  = bus.addr;
                    wdata_next = bus.wdata << {bus.addr[2:0], 3'b000};
                    be_next    = size_mask(dec.size) << bus.addr[2:0];
                    size_next  = dec.size;
                    sgn_next   = dec.sgn;
                    write_next = dec.write;
                    excl_next  = dec.excl;
                    cnt_next   = '0;
                    if (!dec.legal || misaligned(dec.size, bus.addr[2:0])) begin
                        state_next = ST_RESP;
                        rdata_next = '0;
                        err_next   = 1'b1;
                    end else if (dec.excl && dec.write && !tag_hit_in) begin
                        // Failed store-exclusive: report status 1 without touching memory.
                        state_next     = ST_RESP;
                        rdata_next     = 64'd1;
                        err_next       = 1'b0;
                        mon_valid_next = 1'b0;
                    end else begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (bus.mem_ack) begin
                    state_next = ST_RESP;
                    err_next   = 1'b0;
                    rdata_next = write_reg ? 64'd0 : load_ext;
                    if (write_reg) begin
                        if (excl_reg || (mon_tag_reg == addr_reg[63:3]))
                            mon_valid_next = 1'b0;
                    end else if (excl_reg) begin
                        mon_valid_next = 1'b1;
                        mon_tag_next   = addr_reg[63:3];
                    end
                end else if (cnt_reg == 8'(TIMEOUT - 1)) begin
                    state_next     = ST_RESP;
                    err_next       = 1'b1;
                    rdata_next     = '0;
                    mon_valid_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            be_reg        <= '0;
            size_reg      <= SZ_B;
            sgn_reg       <= 1'b0;
            write_reg     <= 1'b0;
            excl_reg      <= 1'b0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
            mon_valid_reg <= 1'b0;
            mon_tag_reg   <= '0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            be_reg        <= be_next;
            size_reg      <= size_next;
            sgn_reg       <= sgn_next;
            write_reg     <= write_next;
            excl_reg      <= excl_next;
            rdata_reg     <= rdata_next;
            err_reg       <= err_next;
            mon_valid_reg <= mon_valid_next;
            mon_tag_reg   <= mon_tag_next;
            cnt_reg       <= cnt_next;
        end
    end

    assign bus.req_ready = (state_reg == ST_IDLE);
    assign bus.rsp_valid = (state_reg == ST_RESP);
    assign bus.mem_req   = (state_reg == ST_REQ);
    assign bus.mem_we    = (state_reg == ST_REQ) && write_reg;
    assign bus.mem_addr  = {addr_reg[63:3], 3'b000};
    assign bus.mem_be    = be_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.rdata     = rdata_reg;
    assign bus.rsp_err   = err_reg;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset
// corner cases, then random traffic against a byte-level reference model.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int TO = 4;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [63:0] rd;
        logic        err;
        int          lat;
        int          reqc;
        logic [7:0]  be;
        logic        we;
        logic [63:0] wd;
    } exp_t;

    typedef struct {
        logic [63:0] rd;
        logic        err;
        int          lat;
        int          reqc;
        logic [7:0]  be;
        logic        we;
        logic [63:0] ma;
        logic [63:0] wd;
        logic        req_stable;
        logic        rsp_stable;
        logic        ready_after;
    } res_t;

    typedef struct {
        logic [10:0] op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] mdata;
        int          ack;
        logic [63:0] rd;
        logic        err;
        int          lat;
        int          reqc;
        logic [7:0]  be;
        logic        we;
        logic [63:0] wd;
    } vec_t;

    // Reference-model exclusive monitor.
    logic        mon_v;
    logic [60:0] mon_tag;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request; ack_wait = REQ cycles to wait before ack (-1: never ack).
    task automatic run_txn(input logic [10:0] op, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [63:0] mdata,
                           input int ack_wait, output res_t r);
        int guard;
        int hold;
        guard = 0;
        r = '{default: '0};
        r.req_stable = 1'b1;
        r.rsp_stable = 1'b1;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            errors++;
            $display("FAIL wait_req_ready: got 0 expected 1 within 50 cycles");
        end
        bus.req_valid = 1'b1;
        bus.opcode    = op;
        bus.addr      = addr;
        bus.wdata     = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        r.lat = 1;
        while (!bus.rsp_valid && r.lat < 40) begin
            if (bus.mem_req) begin
                r.reqc++;
                if (r.reqc == 1) begin
                    r.be = bus.mem_be; r.we = bus.mem_we;
                    r.ma = bus.mem_addr; r.wd = bus.mem_wdata;
                end else if (bus.mem_be !== r.be || bus.mem_we !== r.we ||
                             bus.mem_addr !== r.ma || bus.mem_wdata !== r.wd) begin
                    r.req_stable = 1'b0;
                end
                bus.mem_ack   = (r.reqc == ack_wait + 1);
                bus.mem_rdata = bus.mem_ack ? mdata : {$urandom, $urandom};
            end else begin
                bus.mem_ack = 1'b0;
            end
            @(negedge clk);
            r.lat++;
        end
        bus.mem_ack = 1'b0;
        if (!bus.rsp_valid) begin
            errors++;
            $display("FAIL wait_rsp_valid: got 0 expected 1 within 40 cycles");
            return;
        end
        r.rd  = bus.rdata;
        r.err = bus.rsp_err;
        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.rdata !== r.rd || bus.rsp_err !== r.err || !bus.rsp_valid || bus.req_ready)
                r.rsp_stable = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        r.ready_after = bus.req_ready && !bus.rsp_valid;
    endtask

    task automatic compare(input string tag, input logic [63:0] addr, input exp_t e, input res_t r);
        check({tag, ".rdata"}, r.rd, e.rd);
        check({tag, ".err"}, 64'(r.err), 64'(e.err));
        check({tag, ".latency"}, 64'(r.lat), 64'(e.lat));
        check({tag, ".req_cycles"}, 64'(r.reqc), 64'(e.reqc));
        if (e.reqc > 0) begin
            check({tag, ".mem_be"}, 64'(r.be), 64'(e.be));
            check({tag, ".mem_we"}, 64'(r.we), 64'(e.we));
            check({tag, ".mem_addr"}, r.ma, {addr[63:3], 3'b000});
            check({tag, ".mem_wdata"}, r.wd, e.wd);
            check({tag, ".req_stable"}, 64'(r.req_stable), 64'd1);
        end
        check({tag, ".rsp_stable"}, 64'(r.rsp_stable), 64'd1);
        check({tag, ".ready_after"}, 64'(r.ready_after), 64'd1);
    endtask

    function automatic int nbytes(input logic [10:0] op);
        case (op)
            OPC_D_STURB, OPC_D_LDURB, OPC_D_LDURSB:           return 1;
            OPC_D_STURH, OPC_D_LDURH, OPC_D_LDURSH:           return 2;
            OPC_D_STURW, OPC_D_LDURSW:                        return 4;
            OPC_D_STUR, OPC_D_LDUR, OPC_D_LDXR, OPC_D_STXR:   return 8;
            default:                                          return 0;
        endcase
    endfunction

    // Byte-level model of the specified behaviour; updates the model monitor.
    task automatic model(input logic [10:0] op, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] mdata,
                         input int ack, output exp_t e);
        int  nb;
        int  off;
        logic is_store;
        logic is_signed;
        logic [63:0] v;
        nb        = nbytes(op);
        off       = int'(addr[2:0]);
        is_store  = (op == OPC_D_STURB || op == OPC_D_STURH || op == OPC_D_STURW ||
                     op == OPC_D_STUR  || op == OPC_D_STXR);
        is_signed = (op == OPC_D_LDURSB || op == OPC_D_LDURSH || op == OPC_D_LDURSW);
        e = '{default: '0};
        e.wd = '0;
        for (int i = 0; i + off < 8; i++) e.wd[8*(off+i) +: 8] = wdata[8*i +: 8];
        if (nb == 0 || (off % nb) != 0) begin
            e.err = 1'b1; e.lat = 1;
        end else if (op == OPC_D_STXR && !(mon_v && mon_tag == addr[63:3])) begin
            e.rd = 64'd1; e.lat = 1; mon_v = 1'b0;
        end else begin
            for (int i = 0; i < nb; i++) e.be[off+i] = 1'b1;
            e.we   = is_store;
            e.reqc = (ack >= 0 && ack < TO) ? ack + 1 : TO;
            e.lat  = e.reqc + 1;
            if (!(ack >= 0 && ack < TO)) begin
                e.err = 1'b1; mon_v = 1'b0;
            end else if (is_store) begin
                if (op == OPC_D_STXR || (mon_v && mon_tag == addr[63:3])) mon_v = 1'b0;
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++) v[8*i +: 8] = mdata[8*(off+i) +: 8];
                if (is_signed && v[8*nb-1])
                    for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
                e.rd = v;
                if (op == OPC_D_LDXR) begin mon_v = 1'b1; mon_tag = addr[63:3]; end
            end
        end
    endtask

    vec_t vt[$];
    logic [10:0] ops[12];

    initial begin
        res_t r;
        exp_t e;
        logic flag;
        logic [10:0] op;
        logic [63:0] addr, wdata, mdata;
        int ack;

        bus.req_valid = 1'b0; bus.opcode = '0; bus.addr = '0; bus.wdata = '0;
        bus.rsp_ready = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.req_ready", 64'(bus.req_ready), 64'd1);
        check("reset.rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("reset.mem_req_we", {62'd0, bus.mem_req, bus.mem_we}, 64'd0);
        check("reset.mem_be", 64'(bus.mem_be), 64'd0);
        check("reset.mem_addr", bus.mem_addr, 64'd0);
        check("reset.mem_wdata", bus.mem_wdata, 64'd0);
        check("reset.rdata", bus.rdata, 64'd0);
        check("reset.rsp_err", 64'(bus.rsp_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // op, addr, wdata, mdata, ack_wait, rdata, err, lat, req_cycles, be, we, mem_wdata
        vt.push_back('{OPC_D_LDURSB, 64'h1003, 64'h0, 64'h0000_0000_8000_0000, 3, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 5, 4, 8'h08, 1'b0, 64'h0});
        vt.push_back('{OPC_D_STURH, 64'h2006, 64'hBEEF, 64'h0, 0, 64'h0, 1'b0, 2, 1, 8'hC0, 1'b1, 64'hBEEF_0000_0000_0000});
        vt.push_back('{OPC_D_LDURH, 64'h3001, 64'h0, 64'h0, 0, 64'h0, 1'b1, 1, 0, 8'h00, 1'b0, 64'h0});
        vt.push_back('{OPC_D_LDXR, 64'h4000, 64'h0, 64'h1122_3344_5566_7788, 1, 64'h1122_3344_5566_7788, 1'b0, 3, 2, 8'hFF, 1'b0, 64'h0});
        vt.push_back('{OPC_D_STXR, 64'h4000, 64'hCAFE, 64'h0, 0, 64'h0, 1'b0, 2, 1, 8'hFF, 1'b1, 64'hCAFE});
        vt.push_back('{OPC_D_STXR, 64'h4000, 64'hCAFE, 64'h0, 0, 64'h1, 1'b0, 1, 0, 8'h00, 1'b0, 64'h0});
        vt.push_back('{OPC_D_LDXR, 64'h5000, 64'h0, 64'hAA, 0, 64'hAA, 1'b0, 2, 1, 8'hFF, 1'b0, 64'h0});
        vt.push_back('{OPC_D_STUR, 64'h5000, 64'h1, 64'h0, 0, 64'h0, 1'b0, 2, 1, 8'hFF, 1'b1, 64'h1});
        vt.push_back('{OPC_D_STXR, 64'h5000, 64'h3, 64'h0, 0, 64'h1, 1'b0, 1, 0, 8'h00, 1'b0, 64'h0});
        vt.push_back('{OPC_D_LDXR, 64'h5000, 64'h0, 64'hBB, 0, 64'hBB, 1'b0, 2, 1, 8'hFF, 1'b0, 64'h0});
        vt.push_back('{OPC_D_STUR, 64'h5008, 64'h2, 64'h0, 0, 64'h0, 1'b0, 2, 1, 8'hFF, 1'b1, 64'h2});
        vt.push_back('{OPC_D_STXR, 64'h5000, 64'h3, 64'h0, 0, 64'h0, 1'b0, 2, 1, 8'hFF, 1'b1, 64'h3});
        vt.push_back('{OPC_D_LDUR, 64'h6000, 64'h0, 64'h55, -1, 64'h0, 1'b1, 5, 4, 8'hFF, 1'b0, 64'h0});
        vt.push_back('{OPC_D_LDURSW, 64'h6004, 64'h0, 64'h8000_0000_0000_0000, 0, 64'hFFFF_FFFF_8000_0000, 1'b0, 2, 1, 8'hF0, 1'b0, 64'h0});
        vt.push_back('{OPC_D_LDURB, 64'h6007, 64'h0, 64'hF000_0000_0000_0000, 0, 64'hF0, 1'b0, 2, 1, 8'h80, 1'b0, 64'h0});
        vt.push_back('{11'h000, 64'h7000, 64'h0, 64'h0, 0, 64'h0, 1'b1, 1, 0, 8'h00, 1'b0, 64'h0});
        vt.push_back('{OPC_D_LDXR, 64'h7000, 64'h0, 64'h7, 0, 64'h7, 1'b0, 2, 1, 8'hFF, 1'b0, 64'h0});
        vt.push_back('{OPC_D_LDUR, 64'h7008, 64'h0, 64'h0, -1, 64'h0, 1'b1, 5, 4, 8'hFF, 1'b0, 64'h0});
        vt.push_back('{OPC_D_STXR, 64'h7000, 64'h9, 64'h0, 0, 64'h1, 1'b0, 1, 0, 8'h00, 1'b0, 64'h0});
        vt.push_back('{OPC_D_LDURSH, 64'h9002, 64'h0, 64'h0000_0000_7FFF_0000, 2, 64'h7FFF, 1'b0, 4, 3, 8'h0C, 1'b0, 64'h0});
        vt.push_back('{OPC_D_STURW, 64'h9004, 64'h1234_5678_DEAD_BEEF, 64'h0, 0, 64'h0, 1'b0, 2, 1, 8'hF0, 1'b1, 64'hDEAD_BEEF_0000_0000});
        vt.push_back('{OPC_D_STURB, 64'h9005, 64'hAB, 64'h0, 0, 64'h0, 1'b0, 2, 1, 8'h20, 1'b1, 64'h0000_AB00_0000_0000});
        vt.push_back('{OPC_D_LDXR, 64'h8000, 64'h0, 64'h99, 0, 64'h99, 1'b0, 2, 1, 8'hFF, 1'b0, 64'h0});

        foreach (vt[i]) begin
            e = '{vt[i].rd, vt[i].err, vt[i].lat, vt[i].reqc, vt[i].be, vt[i].we, vt[i].wd};
            run_txn(vt[i].op, vt[i].addr, vt[i].wdata, vt[i].mdata, vt[i].ack, r);
            $display("vec %0d op=%h addr=%h rdata=%h err=%0d lat=%0d", i, vt[i].op, vt[i].addr, r.rd, r.err, r.lat);
            compare($sformatf("vec%0d", i), vt[i].addr, e, r);
        end

        // Reset in the middle of REQ: request drops at once, no response, monitor lost.
        bus.req_valid = 1'b1; bus.opcode = OPC_D_LDUR; bus.addr = 64'h8000; bus.wdata = '0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("midreset.mem_req_before", 64'(bus.mem_req), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset.mem_req", 64'(bus.mem_req), 64'd0);
        check("midreset.req_ready", 64'(bus.req_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.mem_req) flag = 1'b1;
        end
        check("midreset.no_response", 64'(flag), 64'd0);
        e = '{64'h1, 1'b0, 1, 0, 8'h00, 1'b0, 64'h0};
        run_txn(OPC_D_STXR, 64'h8000, 64'h5, 64'h0, 0, r);
        $display("midreset stxr rdata=%h err=%0d lat=%0d", r.rd, r.err, r.lat);
        compare("midreset.stxr", 64'h8000, e, r);

        // Random traffic over four doublewords against the reference model.
        mon_v = 1'b0;
        mon_tag = '0;
        ops = '{OPC_D_STURB, OPC_D_LDURB, OPC_D_LDURSB, OPC_D_STURH, OPC_D_LDURH, OPC_D_LDURSH,
                OPC_D_STURW, OPC_D_LDURSW, OPC_D_STUR, OPC_D_LDUR, OPC_D_LDXR, OPC_D_STXR};
        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 19) == 0) ? 11'h7FF :
                 ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 0) ? OPC_D_LDXR : OPC_D_STXR) :
                 ops[$urandom_range(0, 11)];
            addr  = 64'h100 + 64'(8 * $urandom_range(0, 3)) +
                    (($urandom_range(0, 1) == 0) ? 64'd0 : 64'($urandom_range(0, 7)));
            wdata = {$urandom, $urandom};
            mdata = {$urandom, $urandom};
            ack   = int'($urandom_range(0, 5)) - 1;
            model(op, addr, wdata, mdata, ack, e);
            run_txn(op, addr, wdata, mdata, ack, r);
            $display("rnd %0d op=%h addr=%h ack=%0d rdata=%h err=%0d lat=%0d", n, op, addr, ack, r.rd, r.err, r.lat);
            compare($sformatf("rnd%0d", n), addr, e, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
